// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port flash read arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Wide all-ones pattern; callers truncate to their data width.
  localparam logic [63:0] ABORT_DATA = '1;

  // Watchdog counter width; a disabled watchdog still needs one bit to exist.
  function automatic int wd_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/flash_arb_pick.sv
// Combinational winner select between two toggle-handshake requesters.
module flash_arb_pick
  import flash_arb_pkg::*;
#(
  parameter int PRIO_A = 1
) (
  input  logic pa,
  input  logic pb,
  input  logic rr_last,
  output logic grant_valid,
  output logic grant_id
);

  // Fixed priority gives A every tie; round-robin hands a tie to the port not served last.
  always_comb begin
    grant_valid = pa | pb;
    grant_id    = PORT_A;
    if (pa && pb) begin
      grant_id = (PRIO_A != 0) ? PORT_A : ~rr_last;
    end else if (pb) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/flash_port_arbiter.sv
// Shares one toggle-handshake flash read port between a ROM loader (A) and a
// runtime reader (B), with a hang watchdog that aborts a stuck access.
module flash_port_arbiter
  import flash_arb_pkg::*;
#(
  parameter int AW      = 23,
  parameter int DW      = 16,
  parameter int TIMEOUT = 4095,
  parameter int PRIO_A  = 1
) (
  input  logic          iclk,
  input  logic          ireset,
  input  logic [AW-1:0] ia_addr,
  input  logic          ia_req,
  output logic          oa_ack,
  output logic [DW-1:0] oa_data,
  input  logic [AW-1:0] ib_addr,
  input  logic          ib_req,
  output logic          ob_ack,
  output logic [DW-1:0] ob_data,
  output logic [AW-1:0] ofl_addr,
  output logic          ofl_req,
  input  logic          ifl_ack,
  input  logic [DW-1:0] ifl_data,
  output logic          ogrant,
  output logic          obusy,
  output logic          otimeout
);

  localparam int            WDW     = wd_width(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [DW-1:0]  ABORT   = DW'(ABORT_DATA);

  arb_state_e     state, nstate;
  logic           pa, pb;
  logic           gnt_valid, gnt_id;
  logic           rr_last;
  logic [WDW-1:0] wd;
  logic           fl_done, wd_expire;
  logic           do_grant, do_done, do_abort;
  logic [DW-1:0]  result;

  assign pa        = ia_req ^ oa_ack;
  assign pb        = ib_req ^ ob_ack;
  assign fl_done   = (ifl_ack == ofl_req);
  assign wd_expire = (TIMEOUT != 0) && (wd == WD_LAST);

  flash_arb_pick #(.PRIO_A(PRIO_A)) u_pick (
    .pa          (pa),
    .pb          (pb),
    .rr_last     (rr_last),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  // State register.
  always_ff @(posedge iclk) begin
    if (ireset) state <= IDLE;
    else        state <= nstate;
  end

  // Next state: grant from IDLE, complete or abort from WAIT, resync in DRAIN.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (gnt_valid) nstate = WAIT;
      WAIT: begin
        if (fl_done)        nstate = IDLE;
        else if (wd_expire) nstate = DRAIN;
      end
      DRAIN:   if (fl_done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Decoded strokes for the datapath, plus the busy flag.
  always_comb begin
    obusy    = (state != IDLE);
    do_grant = (state == IDLE) && gnt_valid;
    do_done  = (state == WAIT) && fl_done;
    do_abort = (state == WAIT) && !fl_done && wd_expire;
    result   = do_done ? ifl_data : ABORT;
  end

  // Datapath: launch flash access on grant, return data/ack to the owner on completion or abort.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      oa_ack   <= 1'b0;
      ob_ack   <= 1'b0;
      oa_data  <= '0;
      ob_data  <= '0;
      ofl_addr <= '0;
      ofl_req  <= 1'b0;
      ogrant   <= PORT_A;
      otimeout <= 1'b0;
      wd       <= '0;
      rr_last  <= PORT_B;  // so a first tie goes to A
    end else begin
      if (state == WAIT) wd <= wd + 1'b1;
      if (do_grant) begin
        ofl_addr <= (gnt_id == PORT_B) ? ib_addr : ia_addr;
        ogrant   <= gnt_id;
        ofl_req  <= ~ofl_req;
        wd       <= '0;
      end
      if (do_done || do_abort) begin
        if (ogrant == PORT_B) begin
          ob_data <= result;
          ob_ack  <= ~ob_ack;
        end else begin
          oa_data <= result;
          oa_ack  <= ~oa_ack;
        end
      end
      // Only completed accesses move the fairness pointer; an abort leaves it alone.
      if (do_done)  rr_last  <= ogrant;
      if (do_abort) otimeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Bench: two arbiters (fixed priority with a 16-cycle watchdog, round-robin with
// watchdog off) each behind a flash responder; transactions are checked against a
// transaction-level model of service order and returned data.
module tb_flash_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] a_addr[2], b_addr[2], fl_addr[2];
  logic        a_req[2], a_ack[2], b_req[2], b_ack[2];
  logic        fl_req[2], fl_ack[2], grant[2], busy[2], tmo[2];
  logic [15:0] a_data[2], b_data[2], fl_data[2];
  logic        fl_hold[2], fl_ovr[2];
  logic [15:0] fl_ovr_data[2];
  int          fl_delay[2];
  logic [23:0] glog[2][64];
  int          gcnt[2];
  logic        last[2];
  int          nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] fdat(input logic [22:0] a);
    return a[15:0] ^ {a[22:16], 9'h0A5};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  flash_port_arbiter #(.AW(23), .DW(16), .TIMEOUT(16), .PRIO_A(1)) u_dut0 (
    .iclk(clk), .ireset(rst),
    .ia_addr(a_addr[0]), .ia_req(a_req[0]), .oa_ack(a_ack[0]), .oa_data(a_data[0]),
    .ib_addr(b_addr[0]), .ib_req(b_req[0]), .ob_ack(b_ack[0]), .ob_data(b_data[0]),
    .ofl_addr(fl_addr[0]), .ofl_req(fl_req[0]), .ifl_ack(fl_ack[0]), .ifl_data(fl_data[0]),
    .ogrant(grant[0]), .obusy(busy[0]), .otimeout(tmo[0])
  );

  flash_port_arbiter #(.AW(23), .DW(16), .TIMEOUT(0), .PRIO_A(0)) u_dut1 (
    .iclk(clk), .ireset(rst),
    .ia_addr(a_addr[1]), .ia_req(a_req[1]), .oa_ack(a_ack[1]), .oa_data(a_data[1]),
    .ib_addr(b_addr[1]), .ib_req(b_req[1]), .ob_ack(b_ack[1]), .ob_data(b_data[1]),
    .ofl_addr(fl_addr[1]), .ofl_req(fl_req[1]), .ifl_ack(fl_ack[1]), .ifl_data(fl_data[1]),
    .ogrant(grant[1]), .obusy(busy[1]), .otimeout(tmo[1])
  );

  for (genvar i = 0; i < 2; i++) begin : g_env
    // Flash responder: answers a pending request after fl_delay idle samples unless held.
    initial begin : resp
      int cnt;
      cnt = 0;
      fl_ack[i]  = 1'b0;
      fl_data[i] = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          fl_ack[i] = 1'b0;
          cnt = 0;
        end else if (fl_req[i] != fl_ack[i] && !fl_hold[i]) begin
          if (cnt >= fl_delay[i]) begin
            fl_data[i] = fl_ovr[i] ? fl_ovr_data[i] : fdat(fl_addr[i]);
            fl_ack[i]  = fl_req[i];
            cnt = 0;
          end else cnt++;
        end
      end
    end
    // Grant monitor: logs owner and address of each new flash access.
    initial begin : mon
      logic prev;
      prev = 1'b0;
      gcnt[i] = 0;
      forever begin
        @(negedge clk);
        if (rst) prev = 1'b0;
        else if (fl_req[i] != prev) begin
          prev = fl_req[i];
          glog[i][gcnt[i] % 64] = {grant[i], fl_addr[i]};
          gcnt[i]++;
        end
      end
    end
  end

  // mode 0: A only, 1: B only, 2: A and B together, 3: B toggles while A is in WAIT
  task automatic xact(input int k, input int mode, input int dly, output int cyc);
    logic [22:0] aa, ba;
    logic        ord[2];
    int          n, base;
    aa = 23'($urandom);
    ba = 23'($urandom);
    fl_delay[k] = dly;
    a_addr[k] = aa;
    b_addr[k] = ba;
    base = gcnt[k];
    case (mode)
      0:       begin n = 1; ord[0] = 1'b0; end
      1:       begin n = 1; ord[0] = 1'b1; end
      3:       begin n = 2; ord[0] = 1'b0; ord[1] = 1'b1; end
      default: begin
        n = 2;
        ord[0] = (k == 0 || last[k] == 1'b1) ? 1'b0 : 1'b1;
        ord[1] = ~ord[0];
      end
    endcase
    if (mode != 1) a_req[k] = ~a_req[k];
    cyc = 0;
    if (mode == 3) begin
      @(negedge clk);
      cyc++;
    end
    if (mode != 0) b_req[k] = ~b_req[k];
    while ((a_req[k] != a_ack[k] || b_req[k] != b_ack[k]) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("done k%0d m%0d", k, mode), 32'(cyc < 100), 32'd1);
    chk($sformatf("ngrant k%0d m%0d", k, mode), 32'(gcnt[k] - base), 32'(n));
    for (int j = 0; j < n; j++)
      chk($sformatf("grant%0d k%0d m%0d", j, k, mode), 32'(glog[k][(base + j) % 64]),
          32'({ord[j], ord[j] ? ba : aa}));
    if (mode != 1)
      chk($sformatf("a_data k%0d", k), 32'(a_data[k]), 32'(fl_ovr[k] ? fl_ovr_data[k] : fdat(aa)));
    if (mode != 0)
      chk($sformatf("b_data k%0d", k), 32'(b_data[k]), 32'(fdat(ba)));
    chk($sformatf("idle k%0d", k), 32'(busy[k]), 32'd0);
    last[k] = ord[n - 1];
  endtask

  initial begin
    int cyc, base;
    logic [22:0] ta, tb;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_addr[k] = '0; b_addr[k] = '0; a_req[k] = 1'b0; b_req[k] = 1'b0;
      fl_hold[k] = 1'b0; fl_ovr[k] = 1'b0; fl_ovr_data[k] = '0; fl_delay[k] = 0;
      last[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst acks k%0d", k), 32'({a_ack[k], b_ack[k], fl_req[k]}), 32'd0);
      chk($sformatf("rst data k%0d", k), {a_data[k], b_data[k]}, 32'd0);
      chk($sformatf("rst flags k%0d", k), 32'({fl_addr[k], grant[k], busy[k], tmo[k]}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // single A read, flash answers on the third sample with a fixed word
    fl_ovr[0] = 1'b1; fl_ovr_data[0] = 16'h1234;
    xact(0, 0, 2, cyc);
    chk("lat d2", 32'(cyc), 32'd4);
    fl_ovr[0] = 1'b0;
    xact(0, 0, 0, cyc);
    chk("lat d0", 32'(cyc), 32'd2);
    xact(0, 2, 1, cyc);
    xact(0, 3, 0, cyc);
    for (int r = 0; r < 3; r++) xact(1, 2, 0, cyc);
    xact(1, 3, 2, cyc);

    // watchdog: flash hangs, A is aborted, B waits until the late ack drains
    fl_hold[0] = 1'b1;
    ta = 23'h12345; tb = 23'h54321;
    a_addr[0] = ta; b_addr[0] = tb;
    base = gcnt[0];
    a_req[0] = ~a_req[0];
    cyc = 0;
    while (a_req[0] != a_ack[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo lat", 32'(cyc), 32'd17);
    chk("tmo data", 32'(a_data[0]), 32'hFFFF);
    chk("tmo flag", 32'(tmo[0]), 32'd1);
    chk("drain busy", 32'(busy[0]), 32'd1);
    b_req[0] = ~b_req[0];
    repeat (5) @(negedge clk);
    chk("drain nogrant", 32'(gcnt[0] - base), 32'd1);
    chk("drain b pend", 32'(b_req[0] ^ b_ack[0]), 32'd1);
    fl_hold[0] = 1'b0;
    cyc = 0;
    while (b_req[0] != b_ack[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("post b data", 32'(b_data[0]), 32'(fdat(tb)));
    chk("post b grant", 32'(glog[0][(base + 1) % 64]), 32'({1'b1, tb}));
    chk("post a kept", 32'(a_data[0]), 32'hFFFF);
    chk("tmo sticky", 32'(tmo[0]), 32'd1);

    // randomized traffic on both arbiters
    for (int r = 0; r < 60; r++)
      xact(int'($urandom_range(1, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), cyc);

    // reset in the middle of a hung access
    fl_hold[0] = 1'b1;
    a_req[0] = ~a_req[0];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_req[k] = 1'b0; b_req[k] = 1'b0; last[k] = 1'b1;
    end
    @(negedge clk);
    chk("mid rst acks", 32'({a_ack[0], b_ack[0], fl_req[0]}), 32'd0);
    chk("mid rst data", {a_data[0], b_data[0]}, 32'd0);
    chk("mid rst flags", 32'({fl_addr[0], grant[0], busy[0], tmo[0]}), 32'd0);
    rst = 1'b0;
    fl_hold[0] = 1'b0;
    @(negedge clk);
    xact(0, 0, 0, cyc);
    chk("post rst lat", 32'(cyc), 32'd2);
    xact(1, 2, 1, cyc);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
